lstm_gate_mac: RTL and testbench
================================

// Module: lstm_gate_mac
// PURPOSE
//  Gate compute stage of the LSTM engine, downstream of the gate/network memory sequencer.
//  Per gate: loads bias, accumulates 16-lane dot products of x*wx and h*wh,
//  applies hard-sigmoid or hard-tanh, and emits one WL-bit result.
//  gate_out/gate_valid drive the sequencer's mem_gate_in data and write path.
// PARAMETERS
//  WL        16  data word length, signed fixed point Q(WL-FL).FL
//  FL         8  fractional bits; ONE = 1<<FL
//  ACC_GUARD 10  accumulator guard bits; ACC_W = 2*WL+ACC_GUARD; max 2^(ACC_GUARD-4) ops/gate
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      reset, synchronous, active-high
//  b_valid       in   1      b presented this cycle (opens gate)
//  x_valid       in   1      x/wx vectors presented this cycle
//  h_valid       in   1      h/wh vectors presented this cycle
//  last          in   1      qualifies the accepted op as final op of the gate
//  act_tanh      in   1      sampled with last: 1=hard-tanh (g gate), 0=hard-sigmoid (i,f,o)
//  b             in   WL     bias, signed
//  x, wx, h, wh  in   16*WL  16 signed lanes each, lane k at [k*WL +: WL]
//  gate_out      out  WL     activated result, signed
//  gate_valid    out  1      one-cycle strobe, gate_out valid
//  busy          out  1      gate open or any pipeline stage valid
//  protocol_err  out  1      sticky: >1 of b/x/h_valid in the same cycle
// BEHAVIOUR
//  Reset: gate_out=0, gate_valid=0, busy=0, protocol_err=0; all pipe valids, acc, acc_open cleared.
//  Accept at cycle t; priority b > x > h; dropped strobes set protocol_err (cleared only by rst).
//  Pipeline, no backpressure, one op per cycle sustained:
//   t+1 M: 16 signed WLxWL products registered (2*WL each), op kind, last, act_tanh registered
//   t+2 S: adder-tree sum of 16 products registered, sign-extended to ACC_W
//   t+3 A: bias op: acc <= sext(b)<<FL, acc_open=1; x/h op: acc <= acc + sum.
//          If last: acc cleared to 0 and acc_open cleared after the value goes to stage O.
//   t+4 O: pre = sat_WL(acc >>> FL) (arithmetic shift, saturate to WL signed);
//          tanh: clamp(pre, -ONE, +ONE); sigmoid: clamp((pre>>>2) + (ONE>>1), 0, ONE);
//          gate_out registered, gate_valid=1 for one cycle.
//  Latency: last-qualified op to gate_valid = 4 cycles.
//  Missing bias: acc starts from 0, so the bias is effectively 0.
//  Bias while acc_open: restarts the accumulation; no error.
//  Back-to-back gates: b_valid the cycle after last is legal; the gates do not interfere.
//  last together with b_valid: output = activation(b).
//  Accumulator never wraps within the op limit; saturation only at the pre stage.
//  rst mid-gate: all in-flight ops discarded; no gate_valid for them.
// STRUCTURE
//  lstm_pkg (shared): LANES=16, FL, ONE, ACC_W function, op-kind localparams (OP_B, OP_X, OP_H),
//  sat/clamp functions.
//  Sub-module lstm_dot16: stages M and S (16 multipliers and a registered adder tree), 2-cycle latency.
//  The top holds the valid/kind shift chain, accumulator, activation and error flag.
// TESTING (WL=16, FL=8, ONE=256)
//  1: b=256; x=wx=all 256 (x_valid); h=0 with h_valid+last, act_tanh=0
//     -> acc=17.0; gate_out=256 at +4 cycles; same with act_tanh=1 -> 256.
//  2: b=0; x lane0=128, wx lane0=-256, others 0; then last, act_tanh=0 -> gate_out=96;
//     with act_tanh=1 -> gate_out=0xFF80.
//  3: two gates back-to-back (b,x,h,h,h,h+last x2, no gaps) -> two gate_valid pulses 6 cycles apart,
//     each equal to its isolated result.
//  4: b_valid and x_valid in the same cycle -> protocol_err=1 and stays 1; bias taken, x dropped.
//  5: rst asserted 2 cycles after last -> gate_valid stays 0, all outputs 0 the next cycle, busy=0.
//  6: all lanes 0x7FFF*0x7FFF over 1 x + 4 h ops, act_tanh=1 -> no wrap, gate_out=256;
//     all lanes -0x8000*0x7FFF -> gate_out=0xFF00.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared constants, op-kind codes and fixed-point helpers for the LSTM engine.
// Helpers work on 64-bit signed values so any WL/ACC_W up to 64 bits fits.
package lstm_pkg;

    localparam int LANES         = 16;
    localparam int DEF_WL        = 16;
    localparam int DEF_FL        = 8;
    localparam int DEF_ACC_GUARD = 10;
    localparam int ONE           = 1 << DEF_FL;

    localparam logic [1:0] OP_B = 2'd0;
    localparam logic [1:0] OP_X = 2'd1;
    localparam logic [1:0] OP_H = 2'd2;

    function automatic int acc_w(input int wl, input int guard);
        return 2 * wl + guard;
    endfunction

    function automatic logic signed [63:0] one_of(input int fl);
        return 64'sd1 <<< fl;
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] lo;
        logic signed [63:0] hi;
        lo = -(64'sd1 <<< (w - 1));
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return clamp(v, lo, hi);
    endfunction

endpackage

// File: rtl/lstm_gate_mac_if.sv
// Operand/result bundle between the gate/network memory sequencer and the gate MAC.
// The sequencer side is the master; the MAC uses the slave modport.
interface lstm_gate_mac_if
    import lstm_pkg::*;
#(
    parameter int WL = DEF_WL
) ();
    logic                    b_valid;
    logic                    x_valid;
    logic                    h_valid;
    logic                    last;
    logic                    act_tanh;
    logic signed [WL-1:0]    b;
    logic [LANES*WL-1:0]     x;
    logic [LANES*WL-1:0]     wx;
    logic [LANES*WL-1:0]     h;
    logic [LANES*WL-1:0]     wh;
    logic [WL-1:0]           gate_out;
    logic                    gate_valid;
    logic                    busy;
    logic                    protocol_err;

    modport master (
        output b_valid, x_valid, h_valid, last, act_tanh, b, x, wx, h, wh,
        input  gate_out, gate_valid, busy, protocol_err
    );

    modport slave (
        input  b_valid, x_valid, h_valid, last, act_tanh, b, x, wx, h, wh,
        output gate_out, gate_valid, busy, protocol_err
    );
endinterface

// File: rtl/lstm_dot16.sv
// Two-stage 16-lane signed dot product: registered products (M), registered
// sign-extended sum (S). Pure datapath; validity travels alongside in the parent.
module lstm_dot16
    import lstm_pkg::*;
#(
    parameter int WL    = DEF_WL,
    parameter int ACC_W = acc_w(DEF_WL, DEF_ACC_GUARD)
) (
    input  logic                    clk,
    input  logic [LANES*WL-1:0]     a_vec,
    input  logic [LANES*WL-1:0]     w_vec,
    output logic signed [ACC_W-1:0] sum_q
);

    logic signed [2*WL-1:0]  prod_d [LANES];
    logic signed [2*WL-1:0]  prod_q [LANES];
    logic signed [ACC_W-1:0] sum_d;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_d[k] = (2*WL)'($signed(a_vec[k*WL +: WL])) * (2*WL)'($signed(w_vec[k*WL +: WL]));
        end
        sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d = sum_d + ACC_W'(prod_q[k]);
        end
    end

    // NOTE: pure datapath flops carry no reset; the parent's valid chain decides when they matter.
    always_ff @(posedge clk) begin
        prod_q <= prod_d;
        sum_q  <= sum_d;
    end

endmodule

// File: rtl/lstm_gate_mac.sv
// LSTM gate compute stage: bias load, x*wx / h*wh accumulation, hard-sigmoid or
// hard-tanh activation; one WL-bit result per gate, four cycles after its last op.
module lstm_gate_mac
    import lstm_pkg::*;
#(
    parameter int WL        = DEF_WL,
    parameter int FL        = DEF_FL,
    parameter int ACC_GUARD = DEF_ACC_GUARD
) (
    input logic           clk,
    input logic           rst,
    lstm_gate_mac_if.slave bus
);

    localparam int ACC_W = acc_w(WL, ACC_GUARD);

    logic sel_b, sel_x, sel_h;
    logic [LANES*WL-1:0]     a_vec, w_vec;
    logic signed [ACC_W-1:0] dot_sum, acc_sum;

    logic                    m_valid_d, m_valid_q, s_valid_d, s_valid_q;
    logic [1:0]              m_kind_d, m_kind_q, s_kind_d, s_kind_q;
    logic                    m_last_d, m_last_q, s_last_d, s_last_q;
    logic                    m_tanh_d, m_tanh_q, s_tanh_d, s_tanh_q;
    logic signed [WL-1:0]    m_b_d, m_b_q, s_b_d, s_b_q;
    logic signed [ACC_W-1:0] acc_d, acc_q, fin_acc_d, fin_acc_q;
    logic                    acc_open_d, acc_open_q;
    logic                    fin_valid_d, fin_valid_q, fin_tanh_d, fin_tanh_q;
    logic [WL-1:0]           gate_out_d, gate_out_q;
    logic                    gate_valid_d, gate_valid_q;
    logic                    err_d, err_q;

    function automatic logic [WL-1:0] activate(input logic signed [ACC_W-1:0] a, input logic tanh);
        logic signed [63:0] pre;
        logic signed [63:0] act;
        pre = sat_w(64'(a) >>> FL, WL);
        if (tanh) act = clamp(pre, -one_of(FL), one_of(FL));
        else      act = clamp((pre >>> 2) + (one_of(FL) >>> 1), 64'sd0, one_of(FL));
        return act[WL-1:0];
    endfunction

    lstm_dot16 #(.WL(WL), .ACC_W(ACC_W)) u_dot (
        .clk   (clk),
        .a_vec (a_vec),
        .w_vec (w_vec),
        .sum_q (dot_sum)
    );

    always_comb begin
        // NOTE: every variable gets a value on every path through this block, so no latch can form.
        sel_b = bus.b_valid;
        sel_x = bus.x_valid & ~bus.b_valid;
        sel_h = bus.h_valid & ~bus.b_valid & ~bus.x_valid;
        a_vec = sel_x ? bus.x  : bus.h;
        w_vec = sel_x ? bus.wx : bus.wh;

        m_valid_d = sel_b | sel_x | sel_h;
        m_kind_d  = sel_b ? OP_B : (sel_x ? OP_X : OP_H);
        m_last_d  = bus.last & m_valid_d;
        m_tanh_d  = bus.act_tanh;
        m_b_d     = bus.b;

        s_valid_d = m_valid_q;
        s_kind_d  = m_kind_q;
        s_last_d  = m_last_q;
        s_tanh_d  = m_tanh_q;
        s_b_d     = m_b_q;

        err_d = err_q | (bus.b_valid & bus.x_valid) | (bus.b_valid & bus.h_valid)
                      | (bus.x_valid & bus.h_valid);

        // A bias op replaces the running sum, which is how a mid-gate bias restarts it.
        acc_sum = (s_kind_q == OP_B) ? (ACC_W'(s_b_q) <<< FL) : (acc_q + dot_sum);

        acc_d       = acc_q;
        acc_open_d  = acc_open_q;
        fin_valid_d = 1'b0;
        fin_acc_d   = fin_acc_q;
        fin_tanh_d  = fin_tanh_q;
        if (s_valid_q) begin
            if (s_last_q) begin
                fin_valid_d = 1'b1;
                fin_acc_d   = acc_sum;
                fin_tanh_d  = s_tanh_q;
                acc_d       = '0;
                acc_open_d  = 1'b0;
            end else begin
                acc_d      = acc_sum;
                acc_open_d = 1'b1;
            end
        end

        gate_valid_d = fin_valid_q;
        gate_out_d   = fin_valid_q ? activate(fin_acc_q, fin_tanh_q) : gate_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_kind_q     <= OP_B;
            m_last_q     <= 1'b0;
            m_tanh_q     <= 1'b0;
            s_valid_q    <= 1'b0;
            s_kind_q     <= OP_B;
            s_last_q     <= 1'b0;
            s_tanh_q     <= 1'b0;
            acc_q        <= '0;
            acc_open_q   <= 1'b0;
            fin_valid_q  <= 1'b0;
            fin_tanh_q   <= 1'b0;
            gate_out_q   <= '0;
            gate_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_kind_q     <= m_kind_d;
            m_last_q     <= m_last_d;
            m_tanh_q     <= m_tanh_d;
            s_valid_q    <= s_valid_d;
            s_kind_q     <= s_kind_d;
            s_last_q     <= s_last_d;
            s_tanh_q     <= s_tanh_d;
            acc_q        <= acc_d;
            acc_open_q   <= acc_open_d;
            fin_valid_q  <= fin_valid_d;
            fin_tanh_q   <= fin_tanh_d;
            gate_out_q   <= gate_out_d;
            gate_valid_q <= gate_valid_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        m_b_q     <= m_b_d;
        s_b_q     <= s_b_d;
        fin_acc_q <= fin_acc_d;
    end

    assign bus.gate_out     = gate_out_q;
    assign bus.gate_valid   = gate_valid_q;
    assign bus.busy         = acc_open_q | m_valid_q | s_valid_q | fin_valid_q | gate_valid_q;
    assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_lstm_gate_mac.sv
// Randomized self-checking bench for lstm_gate_mac: an arithmetic gate model
// predicts each result and the cycle it must appear; a monitor compares both.
module tb_lstm_gate_mac;
    import lstm_pkg::*;

    localparam int WL = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lstm_gate_mac_if #(.WL(WL)) bus ();

    lstm_gate_mac #(.WL(WL), .FL(8), .ACC_GUARD(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc = 0;
    int     n_checks = 0;
    int     n_errs = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Gate value from the fixed-point rules: acc carries 2*FL fraction bits.
    function automatic logic [15:0] ref_act(input longint acc, input bit th);
        longint pre;
        longint p;
        pre = acc >>> 8;
        if (pre > 32767)  pre = 32767;
        if (pre < -32768) pre = -32768;
        if (th) begin
            p = pre;
            if (p > 256)  p = 256;
            if (p < -256) p = -256;
        end else begin
            p = (pre >>> 2) + 128;
            if (p > 256) p = 256;
            if (p < 0)   p = 0;
        end
        return 16'(p);
    endfunction

    task automatic idle();
        bus.b_valid  = 1'b0;
        bus.x_valid  = 1'b0;
        bus.h_valid  = 1'b0;
        bus.last     = 1'b0;
        bus.act_tanh = 1'b0;
    endtask

    // kind: 0=bias 1=x 2=h; dup raises x_valid alongside a bias op.
    task automatic op(input int kind, input bit lst, input bit th, input int bv,
                      input int va[16], input int vw[16], input bit dup = 1'b0);
        bus.b_valid  = (kind == 0);
        bus.x_valid  = (kind == 1) || dup;
        bus.h_valid  = (kind == 2);
        bus.last     = lst;
        bus.act_tanh = th;
        bus.b        = 16'(bv);
        for (int k = 0; k < 16; k++) begin
            if (kind == 2) begin
                bus.h[k*16 +: 16]  = 16'(va[k]);
                bus.wh[k*16 +: 16] = 16'(vw[k]);
            end else begin
                bus.x[k*16 +: 16]  = 16'(va[k]);
                bus.wx[k*16 +: 16] = 16'(vw[k]);
            end
        end
        if (kind == 0) m_acc = longint'(bv) * 256;
        else for (int k = 0; k < 16; k++) m_acc += longint'(va[k]) * longint'(vw[k]);
        if (lst) begin
            exp_q.push_back('{cyc + 4, ref_act(m_acc, th)});
            m_acc = 0;
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic int rnd_lane(input bit full);
        logic [15:0] r;
        if (full) begin
            r = 16'($urandom);
            return int'($signed(r));
        end
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    task automatic rnd_vec(input bit full, output int v[16]);
        for (int k = 0; k < 16; k++) v[k] = rnd_lane(full);
    endtask

    task automatic rnd_gate(input bit with_bias, input int nops, input bit th, input bit full);
        int va[16];
        int vw[16];
        if (with_bias) begin
            rnd_vec(full, va);
            op(0, nops == 0, th, rnd_lane(1'b1), va, va);
        end
        for (int i = 0; i < nops; i++) begin
            rnd_vec(full, va);
            rnd_vec(full, vw);
            op(($urandom_range(0, 1) == 0) ? 1 : 2, i == nops - 1, th, 0, va, vw);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.gate_valid) begin
                if (exp_q.size() == 0) begin
                    check("gate_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("gate_cycle", cyc, e.cyc);
                    check("gate_out", longint'(bus.gate_out), longint'(e.val));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("gate_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int z[16];
        int va[16];
        int vw[16];
        for (int k = 0; k < 16; k++) z[k] = 0;
        idle();
        bus.b  = '0;
        bus.x  = '0;
        bus.wx = '0;
        bus.h  = '0;
        bus.wh = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gate_out", longint'(bus.gate_out), 0);
        check("rst_gate_valid", bus.gate_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_protocol_err", bus.protocol_err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Bias 1.0 plus sixteen 1.0*1.0 products saturates both activations at +1.0.
        for (int k = 0; k < 16; k++) va[k] = 256;
        for (int t = 0; t < 2; t++) begin
            op(0, 1'b0, t[0], 256, z, z);
            op(1, 1'b0, t[0], 0, va, va);
            op(2, 1'b1, t[0], 0, z, z);
        end
        check("busy_in_flight", bus.busy, 1);
        drain();

        // Single lane 0.5 * -1.0.
        va = z;
        vw = z;
        va[0] = 128;
        vw[0] = -256;
        for (int t = 0; t < 2; t++) begin
            op(0, 1'b0, t[0], 0, z, z);
            op(1, 1'b0, t[0], 0, va, vw);
            op(2, 1'b1, t[0], 0, z, z);
        end
        drain();

        // Two gates with no gap: the monitor's cycle check pins them 6 cycles apart.
        for (int g = 0; g < 2; g++) begin
            bit th;
            th = g[0];
            rnd_vec(1'b0, va);
            op(0, 1'b0, th, rnd_lane(1'b0) * 4, va, va);
            for (int i = 0; i < 5; i++) begin
                rnd_vec(1'b0, va);
                rnd_vec(1'b0, vw);
                op(i == 0 ? 1 : 2, i == 4, th, 0, va, vw);
            end
        end
        drain();

        // Colliding bias and x strobes: bias wins, x is dropped, error sticks.
        rnd_vec(1'b0, va);
        rnd_vec(1'b0, vw);
        op(0, 1'b0, 1'b1, 64, va, vw, 1'b1);
        check("protocol_err_set", bus.protocol_err, 1);
        op(2, 1'b1, 1'b1, 0, va, vw);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("protocol_err_sticky", bus.protocol_err, 1);

        // Reset two cycles after a last op discards it.
        op(0, 1'b0, 1'b0, 300, z, z);
        op(1, 1'b1, 1'b0, 0, va, vw);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        m_acc = 0;
        @(posedge clk);
        #1;
        check("midrst_gate_valid", bus.gate_valid, 0);
        check("midrst_gate_out", longint'(bus.gate_out), 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_protocol_err", bus.protocol_err, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Worst-case magnitudes over five ops must not wrap the accumulator.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 16; k++) begin
                va[k] = (s == 0) ? 32767 : -32768;
                vw[k] = 32767;
            end
            op(1, 1'b0, 1'b1, 0, va, vw);
            for (int i = 0; i < 4; i++) op(2, i == 3, 1'b1, 0, va, vw);
        end
        drain();

        // Random gates: optional bias, 0..5 MAC ops, random activation and gaps.
        for (int g = 0; g < 40; g++) begin
            int nops;
            bit wb;
            nops = $urandom_range(0, 5);
            wb   = (nops == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            rnd_gate(wb, nops, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("end_busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
